alu_div: RTL
============

# alu_div

Sequential signed integer divider for the ALU arithmetic group; the division counterpart of the sequential multiplier. Takes a signed dividend and divisor and runs one restoring-division iteration per clock on magnitudes. It then applies sign correction and returns quotient and remainder with a one-cycle `done` pulse. It uses the same start/done handshake as the multiplier, so the ALU control sequencer drives both identically.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width (two's complement).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  signed dividend; sampled on the accepting edge.
- `b`  in  WIDTH  signed divisor; sampled on the accepting edge.
- `quotient`  out  WIDTH  signed quotient; registered; reset 0.
- `remainder`  out  WIDTH  signed remainder; registered; reset 0.
- `done`  out  1  one-cycle completion pulse; reset 0.
- `busy`  out  1  high whenever state is not IDLE; reset 0.
- `div_by_zero`  out  1  result flag, valid with `done`; reset 0.
- `overflow`  out  1  result flag for most-negative / −1; reset 0.

## Operation
- States:
  - IDLE: go to LOAD if `start`.
  - LOAD: go to DONE if `b`==0, else go to CALC.
  - CALC: stay WIDTH cycles, then go to FIX.
  - FIX: go to DONE.
  - DONE: go to IDLE.
- LOAD:
  - Captures sign_a = a[MSB] and sign_b = b[MSB].
  - Captures |a| and |b| as unsigned WIDTH bits. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits.
  - Clears the partial remainder R (WIDTH+1 bits) and the iteration counter.
  - Loads the shift register Q with |a|.
- CALC, one iteration per cycle:
  - Shift {R,Q} left by 1.
  - Form T = R − {0,|b|} at WIDTH+1 bits.
  - If T ≥ 0: R = T and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - Increment the counter; exit after the WIDTH-th iteration.
- FIX (truncation toward zero, same as C / Verilog `/` and `%`):
  - `quotient` = (sign_a ^ sign_b) ? −Q : Q.
  - `remainder` = sign_a ? −R[WIDTH−1:0] : R[WIDTH−1:0].
  - `overflow` = 1 iff a = −2^(WIDTH−1) and b = −1. The quotient then wraps to −2^(WIDTH−1) and the remainder is 0.
  - `div_by_zero` = 0.
  - `done` is set to 1.
- Divide by zero, handled in LOAD with no CALC cycles:
  - `quotient` = all ones (−1).
  - `remainder` = `a`.
  - `div_by_zero` = 1, `overflow` = 0, `done` is set to 1.
- DONE: `done` cleared. Results and flags hold until the next completion or reset.
- `start` while `busy`: ignored, with no queuing. `a` and `b` changes after the accepting edge have no effect.
- `reset` mid-operation: next edge forces IDLE, clears every output, abandons the operation.

## Timing
- Edge 0 samples `start` in IDLE; `busy` is high from edge 0.
- Normal division:
  - Edge 1: LOAD.
  - Edges 2..WIDTH+1: CALC.
  - Edge WIDTH+2: FIX, which registers results and `done`.
  - `done` is high for the cycle after edge WIDTH+2, which is edge 10 for WIDTH=8.
  - Edge WIDTH+3: returns to IDLE; `busy` and `done` low.
- Divide by zero: results and `done` are registered at edge 1; IDLE again at edge 2.
- Back-to-back: next `start` is accepted in the first IDLE cycle after DONE. Minimum spacing is WIDTH+4 cycles normal, 3 cycles for divide by zero.
- Outputs change only on the FIX or LOAD result-write edge, or on reset.

## Structure
- Shared package `alu_pkg`:
  - State encoding localparams: IDLE, LOAD, CALC, FIX, DONE.
  - Default datapath WIDTH, shared with the multiplier.
- Sub-module `alu_div_step`: combinational single restoring iteration.
  - Inputs: R, Q, |b|.
  - Outputs: next R, next Q.
  - Instantiated once; the top module keeps FSM, counter, sign handling and output registers.

## Test plan
- a=100, b=7 -> quotient=14, remainder=2, flags 0, `done` one cycle, 10 edges after start.
- Sign combinations:
  - a=−100, b=7 -> q=−14 (0xF2), r=−2 (0xFE).
  - a=100, b=−7 -> q=−14, r=2.
  - a=−100, b=−7 -> q=14, r=−2.
- a=5, b=0 -> q=0xFF, r=5, `div_by_zero`=1, `done` after edge 1, `busy` low after edge 2.
- Most-negative cases:
  - a=−128, b=−1 -> q=0x80, r=0, `overflow`=1.
  - a=−128, b=1 -> q=−128, r=0, `overflow`=0.
  - a=3, b=−128 -> q=0, r=3.
- Hold `start` high continuously with changing a/b -> each accepted operation uses the operands from its accepting edge. Back-to-back results are correct and spaced 12 cycles apart.
- Assert `reset` during CALC iteration 4 -> all outputs 0 and `busy` 0 after that edge. A subsequent 100/7 completes correctly.

Source files
------------

// File: rtl/alu_div_pkg.sv
// Shared ALU arithmetic package.
// Holds the default datapath width (shared by the sequential multiplier and
// divider) and the FSM state encoding used by the sequential divider.
package alu_pkg;

  // Default datapath width for the ALU arithmetic group.
  localparam int ALU_WIDTH = 8;

  // Sequential divider control states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/alu_div_if.sv
// Start/done handshake bundle for the sequential divider.
// master: the ALU control sequencer (drives start, a, b).
// slave : the divider (drives quotient, remainder and status flags).
//   start        request, sampled by the divider only while idle
//   a, b         signed dividend / divisor
//   quotient     signed quotient
//   remainder    signed remainder
//   done         one-cycle completion pulse
//   busy         divider not idle
//   div_by_zero  result flag, valid with done
//   overflow     result flag for most-negative / -1
interface alu_div_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, a, b,
    input  quotient, remainder, done, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, a, b,
    output quotient, remainder, done, busy, div_by_zero, overflow
  );
endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   r_i      partial remainder, WIDTH+1 bits
//   q_i      quotient / dividend shift register, WIDTH bits
//   abs_b_i  divisor magnitude, WIDTH bits
//   r_o      next partial remainder
//   q_o      next shift register value (new quotient bit in LSB)
module alu_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] abs_b_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   r_sh_s;
  logic [WIDTH-1:0] q_sh_s;
  logic [WIDTH:0]   t_s;

  // Shift {R,Q} left by one, trial-subtract the divisor, restore on borrow.
  // R stays below |b| <= 2^(WIDTH-1), so the shifted R fits in WIDTH bits
  // and the MSB of T is a reliable sign bit.
  always_comb begin
    r_sh_s = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
    q_sh_s = {q_i[WIDTH-2:0], 1'b0};
    t_s    = r_sh_s - {1'b0, abs_b_i};
    if (t_s[WIDTH] == 1'b0) begin
      r_o = t_s;
      q_o = {q_sh_s[WIDTH-1:1], 1'b1};
    end else begin
      r_o = r_sh_s;
      q_o = q_sh_s;
    end
  end

endmodule

// File: rtl/alu_div.sv
// Sequential signed integer divider (restoring, one iteration per clock).
// Divides magnitudes, then applies truncate-toward-zero sign correction.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu_div_if slave: start/a/b in; quotient/remainder/done/busy/
//          div_by_zero/overflow out (all outputs registered, reset to 0)
// Latency: done rises WIDTH+2 edges after the accepting edge (1 edge for
// divide by zero); busy falls one edge after done.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  alu_div_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] abs_b_q, abs_b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH:0]   step_r_s;
  logic [WIDTH-1:0] step_q_s;

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_i     (q_q),
    .abs_b_i (abs_b_q),
    .r_o     (step_r_s),
    .q_o     (step_q_s)
  );

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    abs_b_d     = abs_b_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Operands are frozen on the accepting edge.
        if (bus.start) begin
          state_d = ST_LOAD;
          a_d     = bus.a;
          b_d     = bus.b;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        sign_a_d = a_q[WIDTH-1];
        sign_b_d = b_q[WIDTH-1];
        if (b_q == '0) begin
          state_d     = ST_DONE;
          quotient_d  = '1;
          remainder_d = a_q;
          dz_d        = 1'b1;
          ov_d        = 1'b0;
          done_d      = 1'b1;
        end else begin
          state_d = ST_CALC;
          // Unsigned view of the negation: |most-negative| still fits.
          abs_b_d = b_q[WIDTH-1] ? -b_q : b_q;
          q_d     = a_q[WIDTH-1] ? -a_q : a_q;
          r_d     = '0;
          cnt_d   = '0;
        end
      end

      ST_CALC: begin
        r_d   = step_r_s;
        q_d   = step_q_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        state_d     = ST_DONE;
        quotient_d  = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
        remainder_d = sign_a_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        ov_d        = (a_q == MOST_NEG) && (b_q == '1);
        dz_d        = 1'b0;
        done_d      = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      abs_b_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      abs_b_q     <= abs_b_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

endmodule
